// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: control and datapath for the iterative RV32M multiply/divide
// unit in Execute. Operands are held as magnitudes; the sign is applied once at
// the end, so one shift-add / restoring-divide loop covers every funct3.
module muldiv_sequencer #(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [XLEN-1:0] MSB_ONLY = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] hi_q, hi_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier shifting out / dividend -> quotient
    logic [XLEN-1:0] opnd_q, opnd_d; // multiplicand or divisor magnitude
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;
    logic            busy_q;

    logic            accept, is_div, sgn_a, sgn_b, a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;

    assign accept   = (state_q == IDLE) & start & ~flush;
    assign is_div   = funct3[2];
    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2.
    // MUL is taken unsigned: the low half of the product does not depend on sign.
    assign sgn_a    = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
    assign sgn_b    = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
    assign a_neg    = sgn_a & op_a[XLEN-1];
    assign b_neg    = sgn_b & op_b[XLEN-1];
    assign mag_a    = a_neg ? -op_a : op_a;
    assign mag_b    = b_neg ? -op_b : op_b;
    assign b_zero   = (op_b == '0);
    assign ovf      = is_div & ~funct3[0] & (op_a == MSB_ONLY) & (op_b == '1);
    assign special  = FAST_SPEC & is_div & (b_zero | ovf);
    // funct3[1] separates REM* from DIV* within the divide group
    assign spec_res = b_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MSB_ONLY);

    logic [XLEN:0]     add_s, sub_s;
    logic [XLEN-1:0]   hi_n, lo_n, q_c, r_c, fin_res;
    logic [2*XLEN-1:0] prod, prod_c;

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        add_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        sub_s = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};
        if (f3_q[2]) begin
            if (!sub_s[XLEN]) begin
                hi_n = sub_s[XLEN-1:0];
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_n = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_n = add_s[XLEN:1];
            lo_n = {add_s[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection on the final iteration
    always_comb begin
        prod   = {hi_n, lo_n};
        prod_c = neg_q ? -prod : prod;
        q_c    = neg_q ? -lo_n : lo_n;
        r_c    = neg_q ? -hi_n : hi_n;
        case (f3_q)
            3'b000:                fin_res = prod_c[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_res = prod_c[2*XLEN-1:XLEN];
            3'b100, 3'b101:        fin_res = q_c;
            default:               fin_res = r_c;
        endcase
    end

    // Sequencer next-state: IDLE -> RUN (XLEN steps) or straight to FIN -> IDLE
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    f3_d   = funct3;
                    // quotient sign is a^b, but a divide by zero keeps all-ones / rs1
                    neg_d  = (is_div & funct3[1]) ? a_neg : ((a_neg ^ b_neg) & ~(is_div & b_zero));
                    hi_d   = '0;
                    lo_d   = is_div ? mag_a : mag_b;
                    opnd_d = is_div ? mag_b : mag_a;
                    if (special) begin
                        state_d  = FIN;
                        result_d = spec_res;
                        done_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = CW'(XLEN-1);
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    hi_d = hi_n;
                    lo_d = lo_n;
                    if (cnt_q == '0) begin
                        state_d  = FIN;
                        result_d = fin_res;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign stall  = accept | (state_q == RUN);
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed RV32M corner cases plus random ops
// compared against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;

    int tests = 0;
    int failed = 0;

    muldiv_sequencer #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a),
        .op_b(op_b), .flush(flush), .stall(stall), .busy(busy), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics with plain wide arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        int                 sa, sb;
        sa = a;
        sb = b;
        case (f)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin ps = 64'(signed'(sa)) * 64'(signed'(sb)); return ps[63:32]; end
            3'd2: begin ps = 64'(signed'(sa)) * $signed({32'b0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Called at a negedge; issues one op and follows it to done. A nonzero poke
    // pulses a stray start at that cycle of the run.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int poke);
        logic [31:0] exp;
        int lat, n, stall_cnt;
        exp = ref_model(f, a, b);
        lat = ref_latency(f, a, b);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        #1;
        stall_cnt = stall ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (stall) stall_cnt++;
            @(negedge clk);
            n++;
            start = (n == poke);
            if (start) begin funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; end
        end
        start = 1'b0;
        check({tag, "_latency"}, n, lat);
        check({tag, "_stall_cycles"}, stall_cnt, lat);
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_fin"}, {31'b0, stall}, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'b0, done}, 0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        logic [31:0] prev, a, b;
        logic [2:0]  f;
        int          n;
        // reset state
        #2;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_result", result, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // directed cases
        run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        check("mul_7x-3_value", result, 32'hFFFF_FFEB);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulhu_ff_value", result, 32'hFFFF_FFFE);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulhsu_ff_value", result, 32'hFFFF_FFFF);
        run_op("mulh_neg", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_-7_2_value", result, 32'hFFFF_FFFD);
        run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        check("rem_-7_2_value", result, 32'hFFFF_FFFF);
        run_op("divu_5_0", 3'd5, 32'd5, 32'd0, 0);
        check("divu_5_0_value", result, 32'hFFFF_FFFF);
        run_op("rem_5_0", 3'd6, 32'hFFFF_FFFB, 32'd0, 0);
        run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("rem_ovf_value", result, 32'h0);
        run_op("divu_poke", 3'd5, 32'd100, 32'd7, 5);

        // start and flush together in IDLE: nothing happens
        start = 1'b1; flush = 1'b1; funct3 = 3'd4; op_a = 32'd9; op_b = 32'd3;
        #1 check("sf_stall", {31'b0, stall}, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("sf_busy", {31'b0, busy}, 0);

        // flush during RUN: back to IDLE, no done, result untouched
        prev = result;
        start = 1'b1; funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 0);
        check("flush_stall", {31'b0, stall}, 0);
        n = 0;
        repeat (40) begin
            if (done) n++;
            @(negedge clk);
        end
        check("flush_no_done", n, 0);
        check("flush_result", result, prev);

        // random ops against the model, back-to-back
        for (int i = 0; i < 24; i++) begin
            f = 3'($urandom_range(0, 7));
            a = (($urandom_range(0, 5)) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op("rand", f, a, b, 0);
        end

        // async reset between clock edges mid-RUN
        start = 1'b1; funct3 = 3'd5; op_a = 32'd12345; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_stall", {31'b0, stall}, 0);
        check("arst_done", {31'b0, done}, 0);
        check("arst_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst", 3'd7, 32'd17, 32'd5, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
